// File: rtl/lcd_pkg.sv
// Shared opcodes, address map and receive states for the HD44780 responder.
package lcd_pkg;

  localparam logic [7:0] LCD_CLR     = 8'h01;
  localparam logic [7:0] LCD_HOME    = 8'h02;
  localparam logic [7:0] LCD_HOME_M  = 8'hFE;
  localparam logic [7:0] LCD_ENTRY   = 8'h04;
  localparam logic [7:0] LCD_ENTRY_M = 8'hFC;
  localparam logic [7:0] LCD_DISP    = 8'h08;
  localparam logic [7:0] LCD_DISP_M  = 8'hF8;
  localparam logic [7:0] LCD_SETDD   = 8'h80;
  localparam logic [7:0] LCD_SETDD_M = 8'h80;

  localparam logic [7:0] LCD_BLANK = 8'h20;

  localparam logic [3:0] LCD_NIB_INIT = 4'h3;
  localparam logic [3:0] LCD_NIB_4BIT = 4'h2;

  localparam logic [6:0] LCD_L0_BASE = 7'h00;
  localparam logic [6:0] LCD_L1_BASE = 7'h40;
  localparam logic [6:0] LCD_L0_END  = 7'h27;
  localparam logic [6:0] LCD_L1_END  = 7'h67;

  typedef enum logic [1:0] {
    RX_INIT8,
    RX_HI,
    RX_LO
  } rx_state_e;

  // Address counter step with the two-line wrap of the panel.
  function automatic logic [6:0] lcd_step(
    input logic [6:0] a,
    input logic       inc
  );
    logic [6:0] r;
    if (inc) begin
      if (a == LCD_L0_END)
        r = LCD_L1_BASE;
      else if (a == LCD_L1_END)
        r = LCD_L0_BASE;
      else
        r = a + 7'd1;
    end else begin
      if (a == LCD_L0_BASE)
        r = LCD_L1_END;
      else if (a == LCD_L1_BASE)
        r = LCD_L0_END;
      else
        r = a - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// 4-bit HD44780 pin bundle: driver side is master, responder is slave.
interface lcd_hd44780_responder_if;

  logic lcd_rs;
  logic lcd_rw;
  logic lcd_e;
  logic lcd4;
  logic lcd5;
  logic lcd6;
  logic lcd7;

  modport master (
    output lcd_rs, lcd_rw, lcd_e,
    output lcd4, lcd5, lcd6, lcd7
  );

  modport slave (
    input lcd_rs, lcd_rw, lcd_e,
    input lcd4, lcd5, lcd6, lcd7
  );

endinterface

// File: rtl/lcd_ddram.sv
// 32x8 display RAM mirror: one write port, one registered read port.
module lcd_ddram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [32];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[waddr_i] <= wdata_i;
  end

  // Read sees pre-write contents on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata_q <= '0;
    else
      rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Receiving end of the 4-bit HD44780 bus: init handshake, nibble
// reassembly, command subset and a 2x16 DDRAM mirror.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_hd44780_responder_if.slave lcd,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic [6:0] ddram_addr,
  output logic       mode_4bit,
  output logic       disp_on,
  output logic       busy,
  output logic       err
);

  logic [6:0] pins;
  logic [6:0] sync_q [SYNC_STAGES];
  logic       e_prev_q;

  assign pins = {lcd.lcd_rs, lcd.lcd_rw, lcd.lcd_e,
                 lcd.lcd7, lcd.lcd6, lcd.lcd5, lcd.lcd4};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      e_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      e_prev_q <= sync_q[SYNC_STAGES-1][4];
    end
  end

  logic       s_rs;
  logic       s_rw;
  logic       s_e;
  logic [3:0] s_nib;
  logic       strobe;
  logic       accept;

  assign s_rs   = sync_q[SYNC_STAGES-1][6];
  assign s_rw   = sync_q[SYNC_STAGES-1][5];
  assign s_e    = sync_q[SYNC_STAGES-1][4];
  assign s_nib  = sync_q[SYNC_STAGES-1][3:0];
  assign strobe = e_prev_q & ~s_e;

  rx_state_e  state_q, state_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       hi_rs_q, hi_rs_d;
  logic       valid_q, valid_d;
  logic       cmd_rs_q, cmd_rs_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic [6:0] addr_q, addr_d;
  logic       id_q, id_d;
  logic       mode_q, mode_d;
  logic       disp_q, disp_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic [4:0] clr_idx_q, clr_idx_d;

  logic       data_we;
  logic [7:0] byte_v;
  logic [4:0] wr_idx;
  logic       in_win;

  assign accept = strobe & ~s_rw & ~busy_q;
  assign byte_v = {hi_nib_q, s_nib};
  assign wr_idx = {addr_q[6], addr_q[3:0]};
  assign in_win = (addr_q[5:4] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RX_INIT8;
      hi_nib_q   <= '0;
      hi_rs_q    <= 1'b0;
      valid_q    <= 1'b0;
      cmd_rs_q   <= 1'b0;
      cmd_byte_q <= '0;
      addr_q     <= LCD_L0_BASE;
      id_q       <= 1'b1;
      mode_q     <= 1'b0;
      disp_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b1;
      clr_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      hi_nib_q   <= hi_nib_d;
      hi_rs_q    <= hi_rs_d;
      valid_q    <= valid_d;
      cmd_rs_q   <= cmd_rs_d;
      cmd_byte_q <= cmd_byte_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      mode_q     <= mode_d;
      disp_q     <= disp_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      clr_idx_q  <= clr_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_nib_d   = hi_nib_q;
    hi_rs_d    = hi_rs_q;
    valid_d    = 1'b0;
    cmd_rs_d   = cmd_rs_q;
    cmd_byte_d = cmd_byte_q;
    addr_d     = addr_q;
    id_d       = id_q;
    mode_d     = mode_q;
    disp_d     = disp_q;
    err_d      = err_q;
    busy_d     = busy_q;
    clr_idx_d  = clr_idx_q;
    data_we    = 1'b0;

    if (busy_q) begin
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == 5'd31)
        busy_d = 1'b0;
    end

    // Reads and strobes during a clear are dropped, not queued.
    if (strobe && (s_rw || busy_q))
      err_d = 1'b1;

    if (accept) begin
      unique case (state_q)
        RX_INIT8: begin
          valid_d    = 1'b1;
          cmd_rs_d   = s_rs;
          cmd_byte_d = {s_nib, 4'h0};
          if (s_nib == LCD_NIB_INIT) begin
            state_d = RX_INIT8;
          end else if (s_nib == LCD_NIB_4BIT && !s_rs) begin
            state_d = RX_HI;
            mode_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        RX_HI: begin
          hi_nib_d = s_nib;
          hi_rs_d  = s_rs;
          state_d  = RX_LO;
        end
        RX_LO: begin
          state_d    = RX_HI;
          valid_d    = 1'b1;
          cmd_rs_d   = hi_rs_q;
          cmd_byte_d = byte_v;
          if (s_rs != hi_rs_q)
            err_d = 1'b1;
          if (hi_rs_q) begin
            data_we = in_win;
            addr_d  = lcd_step(addr_q, id_q);
          end else begin
            unique case (1'b1)
              (byte_v == LCD_CLR): begin
                busy_d    = 1'b1;
                clr_idx_d = '0;
                addr_d    = LCD_L0_BASE;
                id_d      = 1'b1;
              end
              ((byte_v & LCD_HOME_M) == LCD_HOME):
                addr_d = LCD_L0_BASE;
              ((byte_v & LCD_ENTRY_M) == LCD_ENTRY):
                id_d = byte_v[1];
              ((byte_v & LCD_DISP_M) == LCD_DISP):
                disp_d = byte_v[2];
              ((byte_v & LCD_SETDD_M) == LCD_SETDD):
                addr_d = byte_v[6:0];
              default: ;
            endcase
          end
        end
        default: state_d = RX_INIT8;
      endcase
    end
  end

  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;

  assign ram_we    = busy_q | data_we;
  assign ram_waddr = busy_q ? clr_idx_q : wr_idx;
  assign ram_wdata = busy_q ? LCD_BLANK : byte_v;

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign cmd_valid  = valid_q;
  assign cmd_rs     = cmd_rs_q;
  assign cmd_byte   = cmd_byte_q;
  assign ddram_addr = addr_q;
  assign mode_4bit  = mode_q;
  assign disp_on    = disp_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

Receiving end of the 4-bit HD44780 character-LCD bus that our LCD drivers write to. It samples the `lcd_rs/lcd_rw/lcd_e/lcd4..lcd7` pins, follows the power-on 8-bit→4-bit handshake, reassembles nibble pairs into bytes, and executes the command subset our drivers use. It mirrors the 2×16 display RAM for readback. It is the in-fabric stand-in for the panel, used for self-check on the board and as the bench scoreboard source.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on all LCD pins (≥2).
- `clk` in 1: system clock; everything on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `lcd_rs`, `lcd_rw`, `lcd_e` in 1 each: bus control pins from the driver.
- `lcd4`, `lcd5`, `lcd6`, `lcd7` in 1 each: data nibble, with `lcd7` as the MSB.
- `rd_addr` in 5: readback index. Bit 4 = line, bits 3:0 = column.
- `rd_data` out 8: DDRAM byte at `rd_addr`, registered, 1-cycle latency.
- `cmd_valid` out 1: one-cycle pulse per executed byte or init nibble.
- `cmd_rs` out 1: RS of the executed byte.
- `cmd_byte` out 8: the executed byte. In INIT8 it is `{nibble,4'h0}`.
- `ddram_addr` out 7: current address counter.
- `mode_4bit` out 1: set once the 4-bit switch is done.
- `disp_on` out 1: D bit from the last display-control command.
- `busy` out 1: high while a clear is in progress.
- `err` out 1: sticky error flag; cleared only by reset.

## Operation
- Pins pass through `SYNC_STAGES` flops. A strobe is a falling edge of the synced `lcd_e`. The nibble, `rs` and `rw` are taken from the same synced stage as the strobe.
- Any strobe with `rw=1` is ignored and sets `err` (reads are not supported).
- Any strobe while `busy=1` is dropped and sets `err`.
- Receive FSM:
  - **INIT8** (reset state): each strobe is a whole 8-bit-mode command.
    - Nibble `3`: stay in INIT8.
    - Nibble `2` with rs=0: go to HI and set `mode_4bit`.
    - Any other nibble: set `err` and stay in INIT8.
  - **HI**: latch the upper nibble and rs, then go to LO.
  - **LO**: form the byte from the latched upper nibble and the current lower nibble, execute it, then return to HI.
    - If rs differs between the two halves: set `err`, still execute using the HI rs.
- Execution when rs=0:
  - `0x01` clear: start CLEAR. It writes `0x20` to all 32 entries, one entry per cycle, for 32 cycles with `busy=1`. It sets `ddram_addr=0` and I/D=1.
  - `0x02/0x03` home: `ddram_addr=0`.
  - `0x04–0x07` entry mode: latch I/D (bit 1). The shift bit is ignored.
  - `0x08–0x0F` display control: `disp_on` = bit 2.
  - `0x10–0x3F`: no effect.
  - `0x80|a`: `ddram_addr=a[6:0]`.
- Execution when rs=1 (data write):
  - If `ddram_addr` is in `0x00–0x0F` or `0x40–0x4F`, store the byte at index `{addr[6],addr[3:0]}`. Writes to any other address are discarded without `err`.
  - The address then steps by ±1 per I/D, with these wraps:
    - Increment: `0x27→0x40`, `0x67→0x00`.
    - Decrement: `0x00→0x67`, `0x40→0x27`.
- Reset actions:
  - Return to INIT8.
  - Clear `mode_4bit`, `disp_on` and `err`.
  - `ddram_addr=0`, I/D=1.
  - Start a CLEAR, so `busy=1` for the 32 cycles after reset is released.
- Reset mid-pair discards the latched HI nibble.

## Timing
- Reset values:
  - `cmd_valid=0`, `cmd_rs=0`, `cmd_byte=0`, `ddram_addr=0`.
  - `mode_4bit=0`, `disp_on=0`, `err=0`, `rd_data=0`.
  - `busy=1` on the first cycle after `rst_n` rises.
- Latency:
  - A pin edge is visible internally after `SYNC_STAGES` cycles.
  - `cmd_valid`, the DDRAM write and the `ddram_addr` update all happen 1 cycle after the strobe is detected.
  - `busy` rises in that same cycle for a clear command.
- A `0x01` command causes 32 CLEAR cycles; `busy` falls in the cycle after entry 31 is written.
- Minimum supported spacing between strobes is `SYNC_STAGES+2` cycles. The driver must hold the data pins stable from its E rise until one cycle after its E fall, sampled in the `clk` domain.
- A readback that hits the entry being written in the same cycle returns the old data.

## Structure
- Package `lcd_pkg` holds:
  - command opcodes and masks: `LCD_CLR`, `LCD_HOME`, `LCD_ENTRY`, `LCD_DISP`, `LCD_SETDD`;
  - line base addresses `0x00` and `0x40`, and wrap limits `0x27` and `0x67`;
  - the receive-state enum (INIT8, HI, LO) and `LCD_BLANK=8'h20`.
- Submodule `lcd_ddram`: 32×8 RAM, one write port and one registered read port. No reset on the array; CLEAR initializes it.

## Test plan
- Release reset, wait 40 cycles, read all 32 entries → each is `0x20`, `busy` low by cycle 33, `mode_4bit=0`.
- Send init nibbles `3,3,3,2`, then byte pairs for `0x28, 0x06, 0x0C, 0x01` → after the `2`, `mode_4bit=1`; `cmd_byte` sequence is `30,30,30,20,28,06,0C,01`; `disp_on=1`; `busy` high for 32 cycles.
- Write the 16 data bytes "0,0,0,0" plus 9 spaces, then `0xC0`, then `'3'` → line 0 holds the string, `rd_addr=5'h10` reads `0x33`, `ddram_addr=0x41`.
- `0x80|0x27` then one data byte → nothing stored, `ddram_addr=0x40`, `err=0`.
- Strobe with `rw=1`, strobe during a clear, and an HI/LO pair with mismatched rs → `err` is set and stays set. The rw and busy strobes produce no `cmd_valid`.
- Assert `rst_n` after a lone HI nibble, then send pair `0x80` → treated as two INIT8 nibbles (`8` sets `err`, `0`), no address change.
